// File: rtl/mem_arb_pkg.sv
// ------------------------------------------------------------------
// mem_arb_pkg : shared defaults and helpers for the memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   localparam int DEF_NUM_REQ         = 2;
   localparam int DEF_MAX_OUTSTANDING = 8;
   localparam int DEF_CNT_BITS        = 4;
   localparam int DEF_CREG_ID_BITS    = 4;
   localparam int SRC_LSB             = DEF_CREG_ID_BITS;

   typedef enum logic [1:0] {
      CNT_HOLD      = 2'd0,
      CNT_INC       = 2'd1,
      CNT_DEC       = 2'd2,
      CNT_UNDERFLOW = 2'd3
   } cnt_op_e;

   // A simultaneous issue and return cancel out, so an empty counter never underflows then.
   function automatic cnt_op_e cnt_op(input logic inc, input logic dec, input logic zero);
      if (inc == dec) return CNT_HOLD;
      if (inc) return CNT_INC;
      return zero ? CNT_UNDERFLOW : CNT_DEC;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, owns the priority pointer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int IDX_BITS = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en_i,
   input  logic [NUM_REQ-1:0]  req_i,
   output logic [NUM_REQ-1:0]  grant_o,
   output logic [IDX_BITS-1:0] grant_idx_o,
   output logic                grant_valid_o
);

   logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
   int                  idx;

   always_comb begin
      grant_o       = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      idx           = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (en_i && !grant_valid_o && req_i[IDX_BITS'(idx)]) begin
            grant_valid_o                = 1'b1;
            grant_o[IDX_BITS'(idx)]      = 1'b1;
            grant_idx_o                  = IDX_BITS'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid_o) begin
         rr_ptr_d = (grant_idx_o == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_idx_o + IDX_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ------------------------------------------------------------------
// mem_req_arbiter : shares one in-order memory port among NUM_REQ requesters
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = DEF_NUM_REQ,
   parameter int REQ_BITS        = 1,
   parameter int ADDR_WIDTH      = 32,
   parameter int LINE_WIDTH      = 32,
   parameter int CREG_ID_BITS    = DEF_CREG_ID_BITS,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int CNT_BITS        = DEF_CNT_BITS
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_rw,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ*CREG_ID_BITS-1:0]  req_id,
   output logic [NUM_REQ-1:0]               req_stall,
   output logic [NUM_REQ-1:0]               resp_valid,
   output logic [LINE_WIDTH-1:0]            resp_data,
   output logic [CREG_ID_BITS-1:0]          resp_id,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [LINE_WIDTH-1:0]            mem_data,
   output logic                             mem_rw,
   output logic                             mem_valid,
   output logic [REQ_BITS+CREG_ID_BITS-1:0] mem_id,
   input  logic                             mem_stall,
   input  logic                             mem_ready,
   input  logic [LINE_WIDTH-1:0]            mem_rdata,
   input  logic [REQ_BITS+CREG_ID_BITS-1:0] mem_rid,
   output logic                             err_underflow
);

   localparam int ID_W = REQ_BITS + CREG_ID_BITS;

   logic [NUM_REQ-1:0]      eligible, grant, underflow;
   logic [REQ_BITS-1:0]     grant_idx, rsp_src;
   logic                    grant_valid, rsp_src_ok;

   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [LINE_WIDTH-1:0]   mem_data_q, resp_data_q;
   logic                    mem_rw_q, mem_valid_q, err_q;
   logic [ID_W-1:0]         mem_id_q;
   logic [NUM_REQ-1:0]      resp_valid_q;
   logic [CREG_ID_BITS-1:0] resp_id_q;

   assign rsp_src    = mem_rid[ID_W-1 -: REQ_BITS];
   assign rsp_src_ok = {1'b0, rsp_src} < (REQ_BITS+1)'(NUM_REQ);

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .IDX_BITS (REQ_BITS)
   ) u_rr (
      .clk           (clk),
      .reset         (reset),
      .en_i          (~mem_stall),
      .req_i         (eligible),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid)
   );

   assign req_stall = req_valid & ~grant;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic [CNT_BITS-1:0] cnt_q, cnt_d;
      logic                inc, dec, uf;

      // Writes get no response from memory, so only reads occupy a slot.
      assign inc          = grant[i] & ~req_rw[i];
      assign dec          = mem_ready & rsp_src_ok & (rsp_src == REQ_BITS'(i));
      assign eligible[i]  = req_valid[i] & (req_rw[i] | (cnt_q < CNT_BITS'(MAX_OUTSTANDING)));
      assign underflow[i] = uf;

      always_comb begin
         cnt_d = cnt_q;
         uf    = 1'b0;
         case (cnt_op(inc, dec, cnt_q == '0))
            CNT_INC:       cnt_d = cnt_q + CNT_BITS'(1);
            CNT_DEC:       cnt_d = cnt_q - CNT_BITS'(1);
            CNT_UNDERFLOW: uf    = 1'b1;
            default:       cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) cnt_q <= '0;
         else        cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_rw_q     <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_id_q     <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         if (!mem_stall) begin
            mem_valid_q <= grant_valid;
            if (grant_valid) begin
               mem_addr_q <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               mem_data_q <= req_data[grant_idx*LINE_WIDTH +: LINE_WIDTH];
               mem_rw_q   <= req_rw[grant_idx];
               mem_id_q   <= {grant_idx, req_id[grant_idx*CREG_ID_BITS +: CREG_ID_BITS]};
            end
         end
         resp_valid_q <= '0;
         if (mem_ready && rsp_src_ok) begin
            resp_valid_q[rsp_src] <= 1'b1;
            resp_data_q           <= mem_rdata;
            resp_id_q             <= mem_rid[CREG_ID_BITS-1:0];
         end
         err_q <= err_q | (|underflow) | (mem_ready & ~rsp_src_ok);
      end
   end

   assign mem_addr      = mem_addr_q;
   assign mem_data      = mem_data_q;
   assign mem_rw        = mem_rw_q;
   assign mem_valid     = mem_valid_q;
   assign mem_id        = mem_id_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign resp_id       = resp_id_q;
   assign err_underflow = err_q;

endmodule

`default_nettype wire
